// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that picks one full functional-unit result
// per cycle and broadcasts it on the CDB one cycle later.
//
// Ports:
//   clk                in   clock
//   rst                in   asynchronous, active-high reset
//   fu_full[NUM_FU]    in   unit i holds a completed result
//   fu_result[NUM_FU]  in   result entry of unit i (valid while fu_full[i])
//   fu_dequeue[NUM_FU] out  one-hot grant, combinational (forced 0 in reset)
//   cdb_valid          out  registered broadcast valid
//   cdb_out            out  registered broadcast entry
//   cdb_fu_idx         out  registered index of the producing unit
//   perf_grant_cnt     out  per-unit saturating grant count (CDB_ARB_PERF_CNT_EN)
//   perf_conflict_cnt  out  saturating count of cycles with >=2 units full
//                           (CDB_ARB_PERF_CNT_EN)
//
// Optional feature macro: CDB_ARB_PERF_CNT_EN (performance counters).

package cdb_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic [5:0]  rob_tag;
      logic [6:0]  preg;
      logic [31:0] value;
      logic        exc;
   } cdb_entry_t;
endpackage

module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_FU = 4,
   localparam int unsigned PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_FU-1:0]      fu_full,
   input  cdb_entry_t [NUM_FU-1:0] fu_result,
   output logic [NUM_FU-1:0]      fu_dequeue,
   output logic                   cdb_valid,
   output cdb_entry_t             cdb_out,
   output logic [PTR_W-1:0]       cdb_fu_idx
`ifdef CDB_ARB_PERF_CNT_EN
   ,
   output logic [NUM_FU-1:0][31:0] perf_grant_cnt,
   output logic [31:0]            perf_conflict_cnt
`endif
);

   localparam int unsigned LAST_IDX = NUM_FU - 1;

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic             gnt_found;
   int unsigned      scan_idx;

   // Grant: first full unit scanning upward from rr_ptr with wrap-around.
   always_comb begin
      gnt_found  = 1'b0;
      gnt_idx    = '0;
      scan_idx   = 0;
      fu_dequeue = '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         scan_idx = (32'(rr_ptr) + k) % NUM_FU;
         if (!gnt_found && fu_full[PTR_W'(scan_idx)]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(scan_idx);
         end
      end
      if (gnt_found && !rst) begin
         fu_dequeue[gnt_idx] = 1'b1;
      end
   end

   // Broadcast register and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_valid  <= 1'b0;
         cdb_out    <= '0;
         cdb_fu_idx <= '0;
         rr_ptr     <= '0;
      end else if (gnt_found) begin
         cdb_valid  <= 1'b1;
         cdb_out    <= fu_result[gnt_idx];
         cdb_fu_idx <= gnt_idx;
         if (32'(gnt_idx) == LAST_IDX) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= gnt_idx + PTR_W'(1);
         end
      end else begin
         cdb_valid <= 1'b0;
         cdb_out   <= '0;
      end
   end

`ifdef CDB_ARB_PERF_CNT_EN
   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_grant_cnt    <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (fu_dequeue[i] && (perf_grant_cnt[i] != 32'hFFFF_FFFF)) begin
               perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
            end
         end
         if (($countones(fu_full) >= 2) && (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: self-checking bench for cdb_arbiter (NUM_FU=4) using a
// behavioural grant/broadcast model and a model of the unit handshake.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int PW = 2;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [N-1:0]        fu_full = '0;
   cdb_entry_t [N-1:0]  fu_result = '0;
   logic [N-1:0]        fu_dequeue;
   logic                cdb_valid;
   cdb_entry_t          cdb_out;
   logic [PW-1:0]       cdb_fu_idx;
`ifdef CDB_ARB_PERF_CNT_EN
   logic [N-1:0][31:0]  perf_grant_cnt;
   logic [31:0]         perf_conflict_cnt;
`endif

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .fu_full    (fu_full),
      .fu_result  (fu_result),
      .fu_dequeue (fu_dequeue),
      .cdb_valid  (cdb_valid),
      .cdb_out    (cdb_out),
      .cdb_fu_idx (cdb_fu_idx)
`ifdef CDB_ARB_PERF_CNT_EN
      ,
      .perf_grant_cnt    (perf_grant_cnt),
      .perf_conflict_cnt (perf_conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int         m_ptr;
   logic       m_valid;
   cdb_entry_t m_out;
   int         m_idx;
   int         m_gcnt [N];
   int         m_conf;
   int         last_g;

   // Functional-unit model state
   logic       u_full [N];
   logic       u_cool [N];
   cdb_entry_t u_res  [N];

   function automatic int model_grant(logic [N-1:0] full, int ptr);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (ptr + k) % N;
         if (full[j]) return j;
      end
      return -1;
   endfunction

   function automatic cdb_entry_t rand_entry();
      cdb_entry_t e;
      e.valid   = 1'($urandom);
      e.rob_tag = 6'($urandom);
      e.preg    = 7'($urandom);
      e.value   = $urandom;
      e.exc     = 1'($urandom);
      return e;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 1'b0;
      m_out   = '0;
      m_idx   = 0;
      m_conf  = 0;
      last_g  = -1;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
   endtask

   task automatic units_clear();
      for (int i = 0; i < N; i++) begin
         u_full[i] = 1'b0;
         u_cool[i] = 1'b0;
         u_res[i]  = '0;
      end
   endtask

   task automatic apply_units();
      for (int i = 0; i < N; i++) begin
         fu_full[i]   = u_full[i];
         fu_result[i] = u_res[i];
      end
   endtask

   // mode 0: never reassert, 1: reassert as early as allowed, 2: random
   task automatic update_units(int mode);
      for (int i = 0; i < N; i++) begin
         bit want;
         want = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (i == last_g) begin
            u_full[i] = 1'b0;
            u_cool[i] = 1'b1;
         end else if (u_cool[i]) begin
            u_cool[i] = 1'b0;
            if (want) begin u_full[i] = 1'b1; u_res[i] = rand_entry(); end
         end else if (!u_full[i] && want) begin
            u_full[i] = 1'b1;
            u_res[i]  = rand_entry();
         end
      end
      apply_units();
   endtask

   // One clock: check the combinational grant, then the registered broadcast.
   task automatic step(string name);
      int g;
      logic [N-1:0] exp_deq;
      #1;
      g = model_grant(fu_full, m_ptr);
      exp_deq = (g >= 0) ? (N'(1) << g) : '0;
      n_cmp++;
      if (fu_dequeue !== exp_deq) begin
         n_bad++;
         $display("FAIL %s dequeue: got %b expected %b", name, fu_dequeue, exp_deq);
      end
      if (g >= 0) begin
         m_valid = 1'b1;
         m_out   = fu_result[g];
         m_idx   = g;
         m_ptr   = (g + 1) % N;
         m_gcnt[g]++;
      end else begin
         m_valid = 1'b0;
         m_out   = '0;
      end
      if ($countones(fu_full) >= 2) m_conf++;
      last_g = g;
      @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== m_valid) begin
         n_bad++;
         $display("FAIL %s cdb_valid: got %b expected %b", name, cdb_valid, m_valid);
      end
      n_cmp++;
      if (cdb_out !== m_out) begin
         n_bad++;
         $display("FAIL %s cdb_out: got %h expected %h", name, cdb_out, m_out);
      end
      n_cmp++;
      if (int'(cdb_fu_idx) !== m_idx) begin
         n_bad++;
         $display("FAIL %s cdb_fu_idx: got %0d expected %0d", name, cdb_fu_idx, m_idx);
      end
      n_cmp++;
      if (int'(dut.rr_ptr) !== m_ptr) begin
         n_bad++;
         $display("FAIL %s rr_ptr: got %0d expected %0d", name, dut.rr_ptr, m_ptr);
      end
   endtask

   // Reset with every unit full: grants must be suppressed and outputs zero.
   task automatic do_reset(string name);
      rst = 1'b1;
      fu_full = '1;
      for (int i = 0; i < N; i++) fu_result[i] = rand_entry();
      #1;
      n_cmp++;
      if (fu_dequeue !== '0 || cdb_valid !== 1'b0 || cdb_out !== '0 || cdb_fu_idx !== '0) begin
         n_bad++;
         $display("FAIL %s reset outputs: deq=%b valid=%b out=%h idx=%0d expected all zero",
                  name, fu_dequeue, cdb_valid, cdb_out, cdb_fu_idx);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0 || fu_dequeue !== '0) begin
         n_bad++;
         $display("FAIL %s reset held: valid=%b deq=%b expected 0", name, cdb_valid, fu_dequeue);
      end
      units_clear();
      apply_units();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset("reset");
      for (int c = 0; c < 10; c++) step("idle");
   endtask

   task automatic test_single();
      cdb_entry_t e;
      units_clear();
      e = rand_entry();
      e.value = 32'hDEAD_BEEF;
      u_full[2] = 1'b1;
      u_res[2]  = e;
      apply_units();
      step("single");
      n_cmp++;
      if (cdb_out.value !== 32'hDEAD_BEEF || cdb_fu_idx !== 2'd2 || cdb_valid !== 1'b1
          || dut.rr_ptr !== 2'd3) begin
         n_bad++;
         $display("FAIL single_const: value=%h idx=%0d valid=%b ptr=%0d expected DEADBEEF/2/1/3",
                  cdb_out.value, cdb_fu_idx, cdb_valid, dut.rr_ptr);
      end
      update_units(0);
   endtask

   task automatic test_round_robin();
      int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
      do_reset("rr_reset");
      for (int i = 0; i < N; i++) begin u_full[i] = 1'b1; u_res[i] = rand_entry(); end
      apply_units();
      for (int s = 0; s < 8; s++) begin
         step("round_robin");
         if (s < 6) begin
            n_cmp++;
            if (int'(cdb_fu_idx) !== exp_seq[s] || cdb_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL rr_order[%0d]: idx=%0d valid=%b expected %0d/1",
                        s, cdb_fu_idx, cdb_valid, exp_seq[s]);
            end
         end
         update_units(1);
      end
`ifdef CDB_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (perf_grant_cnt[i] !== 32'd2) begin
            n_bad++;
            $display("FAIL perf_grant[%0d]: got %0d expected 2", i, perf_grant_cnt[i]);
         end
      end
      n_cmp++;
      if (perf_conflict_cnt !== 32'(m_conf)) begin
         n_bad++;
         $display("FAIL perf_conflict: got %0d expected %0d", perf_conflict_cnt, m_conf);
      end
`endif
   endtask

   task automatic test_wrap_skip();
      do_reset("wrap_reset");
      u_full[2] = 1'b1;
      u_res[2]  = rand_entry();
      apply_units();
      step("wrap_setup");
      update_units(0);
      u_full[0] = 1'b1; u_res[0] = rand_entry();
      u_full[1] = 1'b1; u_res[1] = rand_entry();
      apply_units();
      step("wrap_first");
      n_cmp++;
      if (cdb_fu_idx !== 2'd0) begin
         n_bad++;
         $display("FAIL wrap_first_idx: got %0d expected 0", cdb_fu_idx);
      end
      update_units(0);
      step("wrap_second");
      n_cmp++;
      if (cdb_fu_idx !== 2'd1 || cdb_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_second_idx: idx=%0d valid=%b expected 1/1", cdb_fu_idx, cdb_valid);
      end
      update_units(0);
      step("wrap_drain");
   endtask

   task automatic test_async_reset();
      do_reset("async_pre");
      u_full[1] = 1'b1;
      u_res[1]  = rand_entry();
      apply_units();
      step("async_grant");
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (cdb_valid !== 1'b0 || cdb_out !== '0 || cdb_fu_idx !== '0 || fu_dequeue !== '0) begin
         n_bad++;
         $display("FAIL async_clear: valid=%b out=%h idx=%0d deq=%b expected all zero",
                  cdb_valid, cdb_out, cdb_fu_idx, fu_dequeue);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      units_clear();
      model_reset();
      for (int i = 0; i < N; i++) begin u_full[i] = 1'b1; u_res[i] = rand_entry(); end
      apply_units();
      step("async_after");
      n_cmp++;
      if (cdb_fu_idx !== 2'd0 || cdb_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL async_first_grant: idx=%0d valid=%b expected 0/1", cdb_fu_idx, cdb_valid);
      end
   endtask

   task automatic test_random();
      do_reset("random_reset");
      for (int c = 0; c < 400; c++) begin
         update_units(2);
         step("random");
      end
`ifdef CDB_ARB_PERF_CNT_EN
      for (int i = 0; i < N; i++) begin
         n_cmp++;
         if (perf_grant_cnt[i] !== 32'(m_gcnt[i])) begin
            n_bad++;
            $display("FAIL random_perf_grant[%0d]: got %0d expected %0d",
                     i, perf_grant_cnt[i], m_gcnt[i]);
         end
      end
      n_cmp++;
      if (perf_conflict_cnt !== 32'(m_conf)) begin
         n_bad++;
         $display("FAIL random_perf_conflict: got %0d expected %0d", perf_conflict_cnt, m_conf);
      end
`endif
   endtask

   initial begin
      model_reset();
      units_clear();
      test_reset();
      test_single();
      test_round_robin();
      test_wrap_skip();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
